// File: rtl/slow_mem_responder_pkg.sv
// slow_mem_responder_pkg: shared FSM state type and line/address geometry
package slow_mem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int LINE_W = 128;
  localparam int ADDR_HI = 31;
  localparam int ADDR_LO = 4;
  localparam int DEF_LATENCY = 4;
endpackage

// File: rtl/slow_mem_responder_mem_line_array.sv
// mem_line_array: single-port line store, synchronous write, registered read
module mem_line_array
  import slow_mem_responder_pkg::*;
#(
  parameter int IDX_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_BITS-1:0] idx,
  input  logic [LINE_W-1:0]   wdata,
  output logic [LINE_W-1:0]   rdata
);
  logic [LINE_W-1:0] mem [2**IDX_BITS];
  // storage has no reset so contents survive rst_n
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  // read register holds the last read line until the next read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[idx];
endmodule

// File: rtl/slow_mem_responder.sv
// slow_mem_responder: fixed-latency line memory with ready pulse and op counters
module slow_mem_responder
  import slow_mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_LATENCY,
  parameter int IDX_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_HI:ADDR_LO]  mem_addr,
  input  logic [LINE_W-1:0]       mem_wdata,
  output logic [LINE_W-1:0]       mem_rdata,
  output logic                    mem_ready,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
);
  state_t state;
  logic [3:0] cnt;
  logic op_wr;
  logic [IDX_BITS-1:0] idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic access;
  logic unused_addr;
  assign unused_addr = ^mem_addr;
  assign access = (state == WAIT) && (cnt == 4'd0);
  mem_line_array #(.IDX_BITS(IDX_BITS)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .we(access && op_wr),
    .re(access && !op_wr),
    .idx(idx_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );
  // accept in IDLE, count down in WAIT, pulse ready and bump counters in RESP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mem_ready <= 1'b0;
      cnt <= '0;
      rd_count <= '0;
      wr_count <= '0;
      op_wr <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: if (mem_read || mem_write) begin
          op_wr <= mem_write;
          idx_q <= mem_addr[IDX_BITS+3:4];
          wdata_q <= mem_wdata;
          cnt <= 4'(MEM_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == 4'd0) begin
          state <= RESP;
          mem_ready <= 1'b1;
        end else cnt <= cnt - 4'd1;
        RESP: begin
          state <= IDLE;
          if (op_wr) wr_count <= wr_count + {15'd0, ~&wr_count};
          else rd_count <= rd_count + {15'd0, ~&rd_count};
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder: directed checks of latency, data, aliasing and reset abort
module tb_slow_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read = 1'b0;
  logic mem_write = 1'b0;
  logic [31:4] mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic mem_ready;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  int tests = 0;
  int fails = 0;
  int lat;
  int pulses;
  int rst_pulses;
  logic [127:0] rdq;
  localparam logic [127:0] PA5 = {16{8'hA5}};
  localparam logic [127:0] PP = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] PQ = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] POLD = 128'h0BAD_F00D_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] PNEW = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] PX = 128'h5A5A_0000_FFFF_1234_C3C3_3C3C_9999_7777;

  slow_mem_responder #(.MEM_LATENCY(4), .IDX_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic rd, input logic wr, input logic [27:0] a,
                      input logic [127:0] d, input int drop_at,
                      output int l, output int p, output logic [127:0] r);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    l = 0; p = 0; r = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == drop_at) begin
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = a ^ 28'h1;
      end
      if (mem_ready) begin
        p++;
        if (l == 0) begin l = i; r = mem_rdata; end
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {127'd0, mem_ready}, 128'd0);
    chk("rst_rdata", mem_rdata, 128'd0);
    chk("rst_rd_count", {112'd0, rd_count}, 128'd0);
    chk("rst_wr_count", {112'd0, wr_count}, 128'd0);
    rst_n = 1'b1;

    xact(1'b0, 1'b1, 28'h10, PA5, 0, lat, pulses, rdq);
    chk("wr10_latency", 128'(lat), 128'd5);
    chk("wr10_pulses", 128'(pulses), 128'd1);
    chk("wr10_wr_count", {112'd0, wr_count}, 128'd1);
    chk("wr10_rd_count", {112'd0, rd_count}, 128'd0);
    chk("wr10_rdata_kept", mem_rdata, 128'd0);

    xact(1'b1, 1'b0, 28'h10, '0, 0, lat, pulses, rdq);
    chk("rd10_latency", 128'(lat), 128'd5);
    chk("rd10_pulses", 128'(pulses), 128'd1);
    chk("rd10_data", rdq, PA5);
    chk("rd10_rd_count", {112'd0, rd_count}, 128'd1);

    xact(1'b1, 1'b1, 28'h20, 128'h1, 0, lat, pulses, rdq);
    chk("both20_pulses", 128'(pulses), 128'd1);
    chk("both20_wr_count", {112'd0, wr_count}, 128'd2);
    chk("both20_rd_count", {112'd0, rd_count}, 128'd1);
    chk("both20_rdata_kept", mem_rdata, PA5);
    xact(1'b1, 1'b0, 28'h20, '0, 0, lat, pulses, rdq);
    chk("rd20_data", rdq, 128'h1);
    chk("rd20_rd_count", {112'd0, rd_count}, 128'd2);

    xact(1'b0, 1'b1, 28'h40, PP, 0, lat, pulses, rdq);
    xact(1'b0, 1'b1, 28'h41, PQ, 0, lat, pulses, rdq);
    xact(1'b1, 1'b0, 28'h40, '0, 2, lat, pulses, rdq);
    chk("drop_latency", 128'(lat), 128'd5);
    chk("drop_pulses", 128'(pulses), 128'd1);
    chk("drop_data", rdq, PP);
    chk("drop_rd_count", {112'd0, rd_count}, 128'd3);
    chk("drop_wr_count", {112'd0, wr_count}, 128'd4);

    xact(1'b0, 1'b1, 28'h30, POLD, 0, lat, pulses, rdq);
    @(negedge clk);
    mem_write = 1'b1; mem_addr = 28'h30; mem_wdata = PNEW;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {127'd0, mem_ready}, 128'd0);
    chk("abort_rdata", mem_rdata, 128'd0);
    chk("abort_wr_count", {112'd0, wr_count}, 128'd0);
    chk("abort_rd_count", {112'd0, rd_count}, 128'd0);
    mem_write = 1'b0;
    rst_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready) rst_pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready) rst_pulses++;
    end
    chk("abort_no_pulse", 128'(rst_pulses), 128'd0);
    xact(1'b1, 1'b0, 28'h30, '0, 0, lat, pulses, rdq);
    chk("post_rst_latency", 128'(lat), 128'd5);
    chk("post_rst_old_data", rdq, POLD);
    chk("post_rst_rd_count", {112'd0, rd_count}, 128'd1);
    chk("post_rst_wr_count", {112'd0, wr_count}, 128'd0);

    xact(1'b0, 1'b1, 28'h0000105, PX, 0, lat, pulses, rdq);
    xact(1'b1, 1'b0, 28'h0000005, '0, 0, lat, pulses, rdq);
    chk("alias_data", rdq, PX);
    chk("alias_rd_count", {112'd0, rd_count}, 128'd2);
    chk("alias_wr_count", {112'd0, wr_count}, 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
